uart_id_formatter: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_id_formatter.sv | 117 +++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART-side constants and helpers for the reader datapath.
// Holds the ASCII line terminators, default prefixes and the nibble-to-hex character map.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] PREFIX_OK_DEF  = 8'h3E;
  localparam logic [7:0] PREFIX_ERR_DEF = 8'h21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_PULSE,
    ST_WAIT
  } fmt_state_t;

  // Uppercase hex: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/uart_id_formatter.sv
// Renders one tag ID per handshake as "<prefix><hex...>\r\n" and feeds it to the UART
// transmitter one byte at a time over its send/ready handshake.
`timescale 1ns/1ps
module uart_id_formatter
  import uart_pkg::*;
#(
  parameter int         ID_BITS    = 96,
  parameter logic [7:0] PREFIX_OK  = PREFIX_OK_DEF,
  parameter logic [7:0] PREFIX_ERR = PREFIX_ERR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_BITS-1:0] id_data,
  input  logic               id_crc_ok,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic               uart_ready,
  output logic               uart_send,
  output logic [7:0]         uart_byte,
  output logic               busy
);

  localparam int HEX_CHARS = ID_BITS / 4;
  localparam int N         = HEX_CHARS + 3;
  localparam int IDX_W     = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_CR = IDX_W'(N - 2);
  localparam logic [IDX_W-1:0] IDX_LF = IDX_W'(N - 1);

  generate
    if ((ID_BITS < 4) || ((ID_BITS % 4) != 0)) begin : g_bad_id_bits
      $error("uart_id_formatter: ID_BITS must be a positive multiple of 4");
    end
  endgenerate

  fmt_state_t         state, state_nx;
  logic [ID_BITS-1:0] shift, shift_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [7:0]         prefix, prefix_nx;
  logic               send_nx;
  logic [7:0]         byte_nx;
  logic [7:0]         cur_char;
  logic               is_hex;

  assign id_ready = (state == ST_IDLE) && !rst;
  assign busy     = (state != ST_IDLE);

  // Index 0 is the prefix, the last two are CR/LF, everything between is hex.
  always_comb begin
    is_hex   = (idx != '0) && (idx < IDX_CR);
    cur_char = nibble_to_ascii(shift[ID_BITS-1 -: 4]);
    if (idx == '0)         cur_char = prefix;
    else if (idx == IDX_CR) cur_char = ASCII_CR;
    else if (idx == IDX_LF) cur_char = ASCII_LF;
  end

  always_comb begin
    state_nx  = state;
    shift_nx  = shift;
    idx_nx    = idx;
    prefix_nx = prefix;
    send_nx   = 1'b0;
    byte_nx   = uart_byte;
    case (state)
      ST_IDLE: begin
        if (id_valid) begin
          shift_nx  = id_data;
          prefix_nx = id_crc_ok ? PREFIX_OK : PREFIX_ERR;
          idx_nx    = '0;
          state_nx  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (uart_ready) begin
          send_nx  = 1'b1;
          byte_nx  = cur_char;
          if (is_hex) shift_nx = shift << 4;
          state_nx = ST_PULSE;
        end
      end
      // The transmitter only drops ready after sampling send, so ready is not looked at here.
      ST_PULSE: begin
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (uart_ready) begin
          if (idx == IDX_LF) begin
            idx_nx   = '0;
            state_nx = ST_IDLE;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = ST_ISSUE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift     <= '0;
      idx       <= '0;
      prefix    <= 8'h00;
      uart_send <= 1'b0;
      uart_byte <= 8'h00;
    end else begin
      state     <= state_nx;
      shift     <= shift_nx;
      idx       <= idx_nx;
      prefix    <= prefix_nx;
      uart_send <= send_nx;
      uart_byte <= byte_nx;
    end
  end

endmodule
